fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-003 SHALL have en_pc, input, 1, PC advance enable from decode (0 = stall).
REQ-004 SHALL have en_ifid and flush_ifid, input, 1 each, IF/ID register load enable and bubble insert.
REQ-005 SHALL have jump_pred, input, 1, and jump_pred_adr, input, 16, predicted-taken request and its target.
REQ-006 SHALL have jump_pred_miss, input, 1, and pcinc_evac, input, 16, predicted-taken was wrong; resume at the saved fall-through.
REQ-007 SHALL have jump_pred_adr_miss, input, 1, and redirect_adr, input, 16, taken target was wrong; resume at the resolved target.
REQ-008 SHALL have halt_req, input, 1, halt instruction seen in decode.
REQ-009 SHALL have imem_adr, output, 16, instruction memory address, and imem_dat, input, 16, synchronous read data, valid one cycle after imem_adr is sampled.
REQ-010 SHALL have inst_id, pcinc_id, output, 16 each, and flushed, output, 1 (1 = IF/ID holds a bubble).
REQ-011 SHALL have pc, output, 16, the current PC register.

Function
REQ-012 Addressing SHALL be word-based; pc+1 SHALL wrap 0xFFFF -> 0x0000.
REQ-013 Next-PC priority SHALL be: jump_pred_miss -> pcinc_evac; jump_pred_adr_miss -> redirect_adr; jump_pred & en_pc -> jump_pred_adr; en_pc -> pc+1; else pc.
REQ-014 Both miss redirects SHALL apply regardless of en_pc and regardless of state.
REQ-015 imem_adr SHALL equal the combinational next-PC, so imem_dat in cycle n+1 equals mem[pc] after PC updates at the edge ending cycle n.
REQ-016 States SHALL be BOOT, RUN and HALT.
REQ-017 BOOT SHALL be entered on reset and last exactly one cycle: PC held, IF/ID loads a bubble, then RUN.
REQ-018 In RUN with en_ifid=1 and flush_ifid=0, IF/ID SHALL load inst_id=imem_dat, pcinc_id=pc+1 and flushed=0.
REQ-019 flush_ifid=1 SHALL load a bubble: inst_id=0x0000, pcinc_id=0x0000, flushed=1. It overrides en_ifid.
REQ-020 en_ifid=0 with flush_ifid=0 SHALL hold IF/ID unchanged.
REQ-021 halt_req in RUN without a same-cycle miss SHALL move to HALT. In HALT the PC is frozen and every IF/ID load with en_ifid=1 is a bubble.
REQ-022 In HALT, jump_pred_miss or jump_pred_adr_miss SHALL redirect the PC and return to RUN (the halt was speculative). Otherwise HALT persists until reset.
REQ-023 A miss coinciding with halt_req SHALL take the redirect and stay in RUN.
REQ-024 jump_pred SHALL be ignored in BOOT and HALT.

Reset
REQ-025 While reset=0 the block SHALL hold: pc=0x0000, state=BOOT, inst_id=0x0000, pcinc_id=0x0000, flushed=1, imem_adr=0x0000.
REQ-026 Reset SHALL take effect asynchronously, including mid-stall, mid-redirect and in HALT. No pending redirect survives it.

Configuration
REQ-027 With FETCH_PERF_CNT_EN defined, outputs fetch_cnt (16) and bubble_cnt (16) SHALL exist, both reset to 0, wrapping at 0xFFFF.
REQ-028 fetch_cnt SHALL increment on each non-bubble IF/ID load; bubble_cnt SHALL increment on each bubble IF/ID load.
REQ-029 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Boot/sequential fetch: mem[0..3]=0x1111,0x2222,0x3333,0x4444; release reset with en_pc=en_ifid=1. Required: cycle 1 flushed=1; cycle 2 inst_id=0x1111, pcinc_id=0x0001; cycle 3 inst_id=0x2222, pcinc_id=0x0002.
REQ-031 Stall: en_pc=en_ifid=0 for 3 cycles with pc=0x0005. Required: pc, imem_adr=0x0005 and inst_id all unchanged; on resume, next fetch is mem[5].
REQ-032 Priority: jump_pred=1 (0x0040), jump_pred_adr_miss=1 (0x0080) and jump_pred_miss=1 (pcinc_evac=0x0020) in the same cycle. Required: pc=0x0020 next cycle. Without jump_pred_miss, pc=0x0080.
REQ-033 Wrap: pc=0xFFFF, en_pc=1. Required: pc=0x0000 next, pcinc_id=0x0000 for that instruction.
REQ-034 Halt: halt_req=1 at pc=0x0010. Required: pc frozen and flushed=1 on every load. A later jump_pred_adr_miss with redirect_adr=0x0030 gives pc=0x0030, RUN, and mem[0x30] fetched.
REQ-035 Async reset asserted mid-cycle during a flush. Required: outputs at REQ-025 values immediately; with FETCH_PERF_CNT_EN, fetch_cnt=bubble_cnt=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds the fetch_cnt/bubble_cnt performance counters.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_pc,
  input  logic        en_ifid,
  input  logic        flush_ifid,
  input  logic        jump_pred,
  input  logic [15:0] jump_pred_adr,
  input  logic        jump_pred_miss,
  input  logic [15:0] pcinc_evac,
  input  logic        jump_pred_adr_miss,
  input  logic [15:0] redirect_adr,
  input  logic        halt_req,
  output logic [15:0] imem_adr,
  input  logic [15:0] imem_dat,
  output logic [15:0] inst_id,
  output logic [15:0] pcinc_id,
  output logic        flushed,
  output logic [15:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic [15:0] r_pcinc;
  logic        r_flushed;
  logic [15:0] w_pc_inc;
  logic [15:0] w_pc_nxt;
  logic        w_miss;
  logic        w_load;
  logic        w_bubble;

  assign w_pc_inc = r_pc + 16'd1;
  assign w_miss   = jump_pred_miss | jump_pred_adr_miss;

  // Next-PC select: mispredict recovery outranks everything, including BOOT and HALT.
  always_comb begin
    w_pc_nxt = r_pc;
    if (jump_pred_miss) begin
      w_pc_nxt = pcinc_evac;
    end else if (jump_pred_adr_miss) begin
      w_pc_nxt = redirect_adr;
    end else if (r_state != ST_RUN) begin
      w_pc_nxt = r_pc;
    end else if (jump_pred && en_pc) begin
      w_pc_nxt = jump_pred_adr;
    end else if (en_pc) begin
      w_pc_nxt = w_pc_inc;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Next-state logic; a halt seen together with a miss is discarded as speculative.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = (halt_req && !w_miss) ? ST_HALT : ST_RUN;
      ST_HALT: w_state_nxt = w_miss ? ST_RUN : ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // IF/ID load decision: flush and BOOT always insert a bubble, HALT turns loads into bubbles.
  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    if (flush_ifid || (r_state == ST_BOOT)) begin
      w_load   = 1'b1;
      w_bubble = 1'b1;
    end else if (en_ifid) begin
      w_load   = 1'b1;
      w_bubble = (r_state != ST_RUN);
    end else begin
      w_load   = 1'b0;
      w_bubble = 1'b0;
    end
  end

  // PC and state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= 16'h0000;
      r_state <= ST_BOOT;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // IF/ID pipeline register; imem_dat belongs to r_pc, so its fall-through is w_pc_inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst    <= 16'h0000;
      r_pcinc   <= 16'h0000;
      r_flushed <= 1'b1;
    end else if (w_load && w_bubble) begin
      r_inst    <= 16'h0000;
      r_pcinc   <= 16'h0000;
      r_flushed <= 1'b1;
    end else if (w_load) begin
      r_inst    <= imem_dat;
      r_pcinc   <= w_pc_inc;
      r_flushed <= 1'b0;
    end else begin
      r_inst    <= r_inst;
      r_pcinc   <= r_pcinc;
      r_flushed <= r_flushed;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_bubble_cnt;

  // Performance counters for real fetches and inserted bubbles, wrapping naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt  <= 16'h0000;
      r_bubble_cnt <= 16'h0000;
    end else if (w_load && w_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end else if (w_load) begin
      r_fetch_cnt  <= r_fetch_cnt + 16'd1;
    end else begin
      r_fetch_cnt  <= r_fetch_cnt;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  // The memory address is the combinational next PC, forced to zero while reset is held.
  assign imem_adr = reset ? w_pc_nxt : 16'h0000;
  assign inst_id  = r_inst;
  assign pcinc_id = r_pcinc;
  assign flushed  = r_flushed;
  assign pc       = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a synchronous instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_pc, en_ifid, flush_ifid, halt_req;
  logic        jump_pred, jump_pred_miss, jump_pred_adr_miss;
  logic [15:0] jump_pred_adr, pcinc_evac, redirect_adr;
  logic [15:0] imem_adr, imem_dat, inst_id, pcinc_id, pc;
  logic        flushed;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, bubble_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .en_pc(en_pc), .en_ifid(en_ifid), .flush_ifid(flush_ifid),
    .jump_pred(jump_pred), .jump_pred_adr(jump_pred_adr),
    .jump_pred_miss(jump_pred_miss), .pcinc_evac(pcinc_evac),
    .jump_pred_adr_miss(jump_pred_adr_miss), .redirect_adr(redirect_adr),
    .halt_req(halt_req), .imem_adr(imem_adr), .imem_dat(imem_dat),
    .inst_id(inst_id), .pcinc_id(pcinc_id), .flushed(flushed), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // mem[0..3] are fixed; every other word is its address XOR 0xA5A5.
  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: memf = 16'h1111;
      16'h0001: memf = 16'h2222;
      16'h0002: memf = 16'h3333;
      16'h0003: memf = 16'h4444;
      default:  memf = a ^ 16'hA5A5;
    endcase
  endfunction

  always @(posedge clk) imem_dat <= memf(imem_adr);

  typedef struct {
    logic [3:0]  ctl;  // {en_pc, en_ifid, flush_ifid, halt_req}
    logic        jp;
    logic [15:0] jp_adr;
    logic        jpm;
    logic [15:0] evac;
    logic        jam;
    logic [15:0] redir;
    logic [15:0] e_pc, e_inst, e_pcinc;
    logic        e_fl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] ctl, input logic jp, input logic [15:0] jp_adr,
                              input logic jpm, input logic [15:0] evac, input logic jam,
                              input logic [15:0] redir, input logic [15:0] e_pc,
                              input logic [15:0] e_inst, input logic [15:0] e_pcinc,
                              input logic e_fl);
    vec_t v;
    v.ctl = ctl; v.jp = jp; v.jp_adr = jp_adr; v.jpm = jpm; v.evac = evac;
    v.jam = jam; v.redir = redir; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_pcinc = e_pcinc; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {en_pc, en_ifid, flush_ifid, halt_req} = v.ctl;
    jump_pred = v.jp; jump_pred_adr = v.jp_adr;
    jump_pred_miss = v.jpm; pcinc_evac = v.evac;
    jump_pred_adr_miss = v.jam; redirect_adr = v.redir;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc"}, pc, 16'h0000);
    chk({tag, " inst_id"}, inst_id, 16'h0000);
    chk({tag, " pcinc_id"}, pcinc_id, 16'h0000);
    chk({tag, " flushed"}, {15'd0, flushed}, 16'h0001);
    chk({tag, " imem_adr"}, imem_adr, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, " fetch_cnt"}, fetch_cnt, 16'h0000);
    chk({tag, " bubble_cnt"}, bubble_cnt, 16'h0000);
`endif
  endtask

  initial begin
    // BOOT and sequential fetch
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0001, 16'h1111, 16'h0001, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0002, 16'h2222, 16'h0002, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0003, 16'h3333, 16'h0003, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0004, 16'h4444, 16'h0004, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0005, 16'hA5A1, 16'h0005, 1'b0));
    // three-cycle stall at pc=5, then resume fetching mem[5]
    vq.push_back(mk(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0005, 16'hA5A1, 16'h0005, 1'b0));
    vq.push_back(mk(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0005, 16'hA5A1, 16'h0005, 1'b0));
    vq.push_back(mk(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0005, 16'hA5A1, 16'h0005, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0006, 16'hA5A0, 16'h0006, 1'b0));
    // flush, flush overriding en_ifid=0, hold of the bubble, refill
    vq.push_back(mk(4'b1110, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0007, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0008, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0008, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0009, 16'hA5AD, 16'h0009, 1'b0));
    // next-PC priority
    vq.push_back(mk(4'b1100, 1'b1, 16'h0040, 1'b1, 16'h0020, 1'b1, 16'h0080, 16'h0020, 16'hA5AC, 16'h000A, 1'b0));
    vq.push_back(mk(4'b1100, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0080, 16'h0080, 16'hA585, 16'h0021, 1'b0));
    vq.push_back(mk(4'b1100, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0040, 16'hA525, 16'h0081, 1'b0));
    vq.push_back(mk(4'b0000, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0040, 16'hA525, 16'h0081, 1'b0));
    // redirect while en_pc=0, then wrap 0xFFFF -> 0x0000
    vq.push_back(mk(4'b0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hA5E5, 16'h0041, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0000, 16'h5A5A, 16'h0000, 1'b0));
    vq.push_back(mk(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0010, 16'h0010, 16'h5A5A, 16'h0000, 1'b0));
    // halt at pc=0x10, bubbles, ignored jump_pred, exit on adr miss to 0x30
    vq.push_back(mk(4'b0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0010, 16'h5A5A, 16'h0000, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0010, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0010, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0010, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0030, 16'h0030, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0031, 16'hA595, 16'h0031, 1'b0));
    // halt coinciding with a miss stays in RUN
    vq.push_back(mk(4'b1101, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 16'h0, 16'h0020, 16'hA594, 16'h0032, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0021, 16'hA585, 16'h0021, 1'b0));
    // halt then leave HALT through jump_pred_miss
    vq.push_back(mk(4'b0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0021, 16'hA585, 16'h0021, 1'b0));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b1, 16'h0005, 1'b0, 16'h0, 16'h0005, 16'h0000, 16'h0000, 1'b1));
    vq.push_back(mk(4'b1100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0006, 16'hA5A0, 16'h0006, 1'b0));

    // Reset held with a redirect pending on the inputs
    reset = 1'b0;
    drive(mk(4'b1100, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0));
    repeat (2) @(posedge clk);
    #1 chk_reset_state("reset");
    jump_pred_miss = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i]);
      #1 chk($sformatf("v%0d imem_adr", i), imem_adr, vq[i].e_pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", i), pc, vq[i].e_pc);
      chk($sformatf("v%0d inst_id", i), inst_id, vq[i].e_inst);
      chk($sformatf("v%0d pcinc_id", i), pcinc_id, vq[i].e_pcinc);
      chk($sformatf("v%0d flushed", i), {15'd0, flushed}, {15'd0, vq[i].e_fl});
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 16'd16);
    chk("bubble_cnt", bubble_cnt, 16'd7);
`endif

    // Asynchronous reset in the middle of a flush cycle with a redirect requested
    drive(mk(4'b1110, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0777, 16'h0, 16'h0, 16'h0, 1'b0));
    #2 reset = 1'b0;
    #1 chk_reset_state("async reset");
    jump_pred_adr_miss = 1'b0;
    flush_ifid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reboot pc", pc, 16'h0000);
    chk("reboot flushed", {15'd0, flushed}, 16'h0001);
    @(posedge clk);
    #1;
    chk("reboot pc+1", pc, 16'h0001);
    chk("reboot inst_id", inst_id, 16'h1111);
    chk("reboot pcinc_id", pcinc_id, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
